alu_md_control_unit: RTL and testbench

Successor to the combinational ALU selection decoder. It keeps the base RV32I ALU_Selection decode and adds a multi-cycle RV32M (MUL/DIV/REM) execution sequencer with a start/busy/done handshake to the EX stage. Base ops stay single-cycle through the existing ALU. M ops use an internal iterative shift-add multiplier and restoring divider, and raise busy_o so the pipeline holds until the result is ready.

---
 rtl/alu_md_control_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_alu_md_control_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md_control_unit.sv
// alu_md_control_unit
//   Base RV32I ALU_Selection decode plus a multi-cycle RV32M sequencer
//   (iterative shift-add multiplier, restoring divider).
//
//   Each M op raises busy_o until its result is ready. When the result is
//   ready, done_o pulses for one cycle and md_result_o holds the result.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start_i         EX-stage instruction valid
//   flush_i         abort any in-flight M op
//   ALUOp           00 ld/st/jump, 01 branch, 10 R-format, 11 unused
//   funct3          instruction bits [14:12]
//   Inst_30         instruction bit 30
//   Inst_25         instruction bit 25 (M-extension select)
//   op_a, op_b      rs1 / rs2 values
//   ALU_Selection   base ALU op select:
//                     ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5,
//                     SRL=6, SRA=7, OR=8, AND=9, PASS=10
//   md_sel_o        result mux select, 1 = use md_result_o
//   busy_o          stall request to the pipeline
//   done_o          one-cycle pulse, md_result_o valid
//   md_result_o     registered M-op result
module alu_md_control_unit #(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic            Inst_30,
  input  logic            Inst_25,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [3:0]      ALU_Selection,
  output logic            md_sel_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] md_result_o
);

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluAnd  = 4'd9;
  localparam logic [3:0] AluPass = 4'd10;

  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Mulhsu = 3'b010;
  localparam logic [2:0] F3Mulhu  = 3'b011;
  localparam logic [2:0] F3Div    = 3'b100;
  localparam logic [2:0] F3Divu   = 3'b101;
  localparam logic [2:0] F3Rem    = 3'b110;

  localparam int unsigned   CntW    = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MostNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  // acc_q: product high word / partial remainder.
  // lo_q:  multiplier shifting out / dividend shifting into quotient.
  logic [XLEN-1:0]   acc_q, lo_q, mcand_q, md_result_q;
  logic [2:0]        f3_q;
  logic              neg_q, done_q;

  logic              m_op;
  logic              accept;

  // ---------------------------------------------------------------------------
  // Base decode
  // ---------------------------------------------------------------------------
  always_comb begin
    m_op          = ENABLE_M && (ALUOp == 2'b10) && Inst_25;
    ALU_Selection = AluPass;
    case (ALUOp)
      2'b00: ALU_Selection = AluAdd;
      2'b01: ALU_Selection = AluSub;
      2'b10: begin
        if (!Inst_25) begin
          case ({Inst_30, funct3})
            4'b0000: ALU_Selection = AluAdd;
            4'b1000: ALU_Selection = AluSub;
            4'b0001: ALU_Selection = AluSll;
            4'b0010: ALU_Selection = AluSlt;
            4'b0011: ALU_Selection = AluSltu;
            4'b0100: ALU_Selection = AluXor;
            4'b0101: ALU_Selection = AluSrl;
            4'b1101: ALU_Selection = AluSra;
            4'b0110: ALU_Selection = AluOr;
            4'b0111: ALU_Selection = AluAnd;
            default: ALU_Selection = AluPass;
          endcase
        end
      end
      default: ALU_Selection = AluPass;
    endcase
  end

  assign md_sel_o = m_op;
  assign accept   = (state_q == StIdle) && start_i && m_op && !flush_i;
  // The combinational term stalls in the same cycle the instruction arrives.
  assign busy_o   = accept || (state_q == StCalc);

  // ---------------------------------------------------------------------------
  // Operand preparation (sampled only when accept is high)
  // ---------------------------------------------------------------------------
  logic            signed_a, signed_b, a_neg, b_neg, res_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    signed_a = (funct3 == F3Mulh) || (funct3 == F3Mulhsu) ||
               (funct3 == F3Div)  || (funct3 == F3Rem);
    signed_b = (funct3 == F3Mulh) || (funct3 == F3Div) || (funct3 == F3Rem);
    a_neg    = signed_a && op_a[XLEN-1];
    b_neg    = signed_b && op_b[XLEN-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    // Remainder follows the dividend; everything else uses sign(a) xor sign(b).
    res_neg  = (funct3 == F3Rem) ? a_neg : (a_neg ^ b_neg);
    div_zero = funct3[2] && (op_b == '0);
    div_ovf  = ((funct3 == F3Div) || (funct3 == F3Rem)) &&
               (op_a == MostNeg) && (op_b == '1);
    // funct3[1] distinguishes REM/REMU from DIV/DIVU.
    if (div_zero) begin
      special_res = funct3[1] ? op_a : '1;
    end else begin
      special_res = funct3[1] ? '0 : op_a;
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration of multiply or divide, plus the final sign-corrected result
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   acc_n, lo_n;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   calc_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    // Partial remainder is always below the divisor, so the shifted value fits
    // in XLEN+1 bits and the top bit of the difference is a clean borrow.
    div_ge    = !div_diff[XLEN];
    if (f3_q[2]) begin
      acc_n = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      lo_n  = {lo_q[XLEN-2:0], div_ge};
    end else begin
      acc_n = mul_sum[XLEN:1];
      lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};
    end

    prod   = {acc_n, lo_n};
    prod_s = neg_q ? -prod : prod;
    case (f3_q)
      F3Mul:                       calc_res = lo_n;
      F3Mulh, F3Mulhsu, F3Mulhu:   calc_res = prod_s[2*XLEN-1:XLEN];
      F3Div, F3Divu:               calc_res = neg_q ? -lo_n : lo_n;
      default:                     calc_res = neg_q ? -acc_n : acc_n;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      mcand_q     <= '0;
      f3_q        <= '0;
      neg_q       <= 1'b0;
      md_result_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            f3_q  <= funct3;
            neg_q <= res_neg;
            cnt_q <= '0;
            acc_q <= '0;
            if (funct3[2]) begin
              mcand_q <= b_mag;
              lo_q    <= a_mag;
            end else begin
              mcand_q <= a_mag;
              lo_q    <= b_mag;
            end
            if (div_zero || div_ovf) begin
              md_result_q <= special_res;
              done_q      <= 1'b1;
              state_q     <= StDone;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          if (flush_i) begin
            state_q <= StIdle;
          end else begin
            acc_q <= acc_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
              md_result_q <= calc_res;
              done_q      <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign done_o      = done_q;
  assign md_result_o = md_result_q;

endmodule

// File: tb/tb_alu_md_control_unit.sv
// Self-checking bench for alu_md_control_unit: scoreboard queue filled at
// issue time from a plain-arithmetic reference model, drained by a monitor
// whenever done_o pulses.
module tb_alu_md_control_unit;

  localparam int XLEN = 32;

  localparam logic [3:0] SEL_ADD  = 4'd0;
  localparam logic [3:0] SEL_SUB  = 4'd1;
  localparam logic [3:0] SEL_SLL  = 4'd2;
  localparam logic [3:0] SEL_SLT  = 4'd3;
  localparam logic [3:0] SEL_SLTU = 4'd4;
  localparam logic [3:0] SEL_XOR  = 4'd5;
  localparam logic [3:0] SEL_SRL  = 4'd6;
  localparam logic [3:0] SEL_SRA  = 4'd7;
  localparam logic [3:0] SEL_OR   = 4'd8;
  localparam logic [3:0] SEL_AND  = 4'd9;
  localparam logic [3:0] SEL_PASS = 4'd10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_i = 1'b0;
  logic            flush_i = 1'b0;
  logic [1:0]      ALUOp = 2'b00;
  logic [2:0]      funct3 = 3'b000;
  logic            Inst_30 = 1'b0;
  logic            Inst_25 = 1'b0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;

  logic [3:0]      alu_sel, alu_sel1;
  logic            md_sel, md_sel1, busy, busy1, done, done1;
  logic [XLEN-1:0] md_res, md_res1;

  alu_md_control_unit #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .flush_i(flush_i),
    .ALUOp(ALUOp), .funct3(funct3), .Inst_30(Inst_30), .Inst_25(Inst_25),
    .op_a(op_a), .op_b(op_b), .ALU_Selection(alu_sel), .md_sel_o(md_sel),
    .busy_o(busy), .done_o(done), .md_result_o(md_res)
  );

  alu_md_control_unit #(.XLEN(XLEN), .ENABLE_M(1'b0)) dut_nom (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .flush_i(flush_i),
    .ALUOp(ALUOp), .funct3(funct3), .Inst_30(Inst_30), .Inst_25(Inst_25),
    .op_a(op_a), .op_b(op_b), .ALU_Selection(alu_sel1), .md_sel_o(md_sel1),
    .busy_o(busy1), .done_o(done1), .md_result_o(md_res1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0] res;
    int              cyc;
  } exp_t;

  exp_t            sb[$];
  int              n_cmp = 0;
  int              n_bad = 0;
  logic [XLEN-1:0] last_res = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: results straight from 64-bit arithmetic.
  function automatic logic [XLEN-1:0] ref_md(input logic [2:0] f3,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    longint      sa, sb_;
    logic [63:0] ua, ub, p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub;             return p[31:0];  end
      3'd1: begin p = 64'(sa * sb_);       return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      3'd3: begin p = ua * ub;             return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = 64'(sa / sb_); return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = 64'(sa % sb_); return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [3:0] ref_sel(input logic [1:0] op, input logic i30,
                                         input logic [2:0] f3, input logic i25);
    if (op == 2'b00) return SEL_ADD;
    if (op == 2'b01) return SEL_SUB;
    if (op == 2'b11 || i25) return SEL_PASS;
    case ({i30, f3})
      4'b0000: return SEL_ADD;
      4'b1000: return SEL_SUB;
      4'b0001: return SEL_SLL;
      4'b0010: return SEL_SLT;
      4'b0011: return SEL_SLTU;
      4'b0100: return SEL_XOR;
      4'b0101: return SEL_SRL;
      4'b1101: return SEL_SRA;
      4'b0110: return SEL_OR;
      4'b0111: return SEL_AND;
      default: return SEL_PASS;
    endcase
  endfunction

  // Monitor: pops one expectation per done_o pulse.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("md_result", 64'(md_res), 64'(e.res));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
    if (done1) check("nom_done", 64'(done1), 64'd0);
  end

  task automatic chk_dec(input logic [1:0] op, input logic i30, input logic [2:0] f3,
                         input logic i25);
    @(negedge clk);
    start_i = 1'b1;
    // Only non-M encodings are presented with start_i; M ones decode idle.
    if (op == 2'b10 && i25) start_i = 1'b0;
    ALUOp = op; Inst_30 = i30; funct3 = f3; Inst_25 = i25;
    #1;
    check("dec_sel", 64'(alu_sel), 64'(ref_sel(op, i30, f3, i25)));
    check("dec_mdsel", 64'(md_sel), 64'(op == 2'b10 && i25));
    check("dec_busy", 64'(busy), 64'd0);
    check("nom_sel", 64'(alu_sel1), 64'(ref_sel(op, i30, f3, i25)));
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic do_m(input logic [2:0] f3, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b);
    exp_t e;
    int   lat, bad;
    bit   got;
    @(negedge clk);
    ALUOp = 2'b10; Inst_25 = 1'b1; Inst_30 = 1'b0; funct3 = f3;
    op_a = a; op_b = b; start_i = 1'b1;
    lat   = ref_lat(f3, a, b);
    e.res = ref_md(f3, a, b);
    e.cyc = cyc + lat;
    sb.push_back(e);
    last_res = e.res;
    #1;
    check("busy_issue", 64'(busy), 64'd1);
    check("mdsel_issue", 64'(md_sel), 64'd1);
    check("nom_pass", 64'(alu_sel1), 64'(SEL_PASS));
    check("nom_busy", 64'(busy1), 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    if (lat > 1) begin
      bad = 0;
      for (int k = 1; k <= XLEN; k++) begin
        if (k > 1) @(negedge clk);
        if (busy !== 1'b1) bad++;
      end
      check("busy_span", 64'(bad), 64'd0);
    end
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(posedge clk);
      if (sb.size() == 0) got = 1'b1;
    end
    if (!got) begin
      check("done_timeout", 64'(got), 64'd1);
      sb.delete();
    end
  endtask

  function automatic logic [XLEN-1:0] pick_opnd();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'(1);
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_result", 64'(md_res), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Base decode, directed then random.
    chk_dec(2'b10, 1'b1, 3'b101, 1'b0);
    chk_dec(2'b01, 1'b0, 3'b000, 1'b0);
    chk_dec(2'b11, 1'b0, 3'b000, 1'b0);
    chk_dec(2'b00, 1'b1, 3'b111, 1'b0);
    for (int i = 0; i < 30; i++)
      chk_dec(2'($urandom_range(0, 3)), 1'($urandom), 3'($urandom), 1'($urandom));

    // Directed M ops.
    do_m(3'd0, 32'd7, 32'hFFFF_FFFD);
    do_m(3'd1, 32'h8000_0000, 32'h8000_0000);
    do_m(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_m(3'd4, 32'hFFFF_FFF9, 32'd2);
    do_m(3'd6, 32'hFFFF_FFF9, 32'd2);
    do_m(3'd5, 32'd100, 32'd7);
    do_m(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    do_m(3'd4, 32'd100, 32'd0);
    do_m(3'd7, 32'd100, 32'd0);
    do_m(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    do_m(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush in CALC: no done pulse, result unchanged.
    @(negedge clk);
    ALUOp = 2'b10; Inst_25 = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    check("flush_result", 64'(md_res), 64'(last_res));

    // Asynchronous reset mid-CALC, then a clean op.
    @(negedge clk);
    ALUOp = 2'b10; Inst_25 = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_result", 64'(md_res), 64'd0);
    last_res = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_m(3'd5, 32'd100, 32'd7);

    // Random M ops.
    for (int i = 0; i < 40; i++)
      do_m(3'($urandom), pick_opnd(), pick_opnd());

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
